// File: rtl/shadow_compare_counter.sv
// shadow_compare_counter: multi-channel timer whose period, compare and mode shadows reload only at the period boundary.
// Define SHADOW_COUNTER_UPDOWN_EN to build the up-down (triangle) mode and the i_updown_mode port.
module shadow_compare_counter #(
    parameter int BIT_WIDTH = 32,
    parameter int CHANNELS  = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic [BIT_WIDTH-1:0]          i_period_value,
    input  logic [CHANNELS*BIT_WIDTH-1:0] i_compare_values,
`ifdef SHADOW_COUNTER_UPDOWN_EN
    input  logic                          i_updown_mode,
`endif
    output logic [BIT_WIDTH-1:0]          o_counter_value,
    output logic                          o_counter_overflow,
    output logic                          o_counter_underflow,
    output logic [CHANNELS-1:0]           o_compare_out
);
    logic [BIT_WIDTH-1:0]          r_count;
    logic [BIT_WIDTH-1:0]          r_period;
    logic [CHANNELS*BIT_WIDTH-1:0] r_compare;
    logic                          r_load_pending;
    logic                          r_overflow;
    logic [BIT_WIDTH-1:0]          w_term;
    logic [BIT_WIDTH-1:0]          w_next_count;
    logic                          w_next_overflow;
    logic                          w_reload;
`ifdef SHADOW_COUNTER_UPDOWN_EN
    typedef enum logic {UP, DOWN} dir_t;
    dir_t                          r_dir;
    dir_t                          w_next_dir;
    logic                          r_mode;
    logic                          r_underflow;
    logic                          w_next_underflow;
    logic [BIT_WIDTH-1:0]          w_new_term;
    assign w_new_term = i_period_value - 1'b1;
`endif
    assign w_term = r_period - 1'b1;
    always_comb begin
        w_next_count    = r_count;
        w_next_overflow = 1'b0;
        w_reload        = r_load_pending;
`ifdef SHADOW_COUNTER_UPDOWN_EN
        w_next_underflow = 1'b0;
        w_next_dir       = r_dir;
`endif
        if (!r_load_pending && i_enable) begin
`ifdef SHADOW_COUNTER_UPDOWN_EN
            // A terminal of 0 degenerates to up mode regardless of the mode shadow
            if (r_mode && w_term != '0) begin
                if (r_dir == UP) begin
                    w_next_overflow = (r_count == w_term);
                    w_next_count    = (r_count == w_term) ? w_term - 1'b1 : r_count + 1'b1;
                    w_next_dir      = (r_count == w_term) ? DOWN : UP;
                end else begin
                    w_next_underflow = (r_count == '0);
                    w_reload         = (r_count == '0);
                    w_next_count     = (r_count != '0) ? r_count - 1'b1 : (w_new_term == '0) ? '0 : BIT_WIDTH'(1);
                    w_next_dir       = (r_count == '0) ? UP : DOWN;
                end
            end else begin
                w_next_dir = UP;
`else
            begin
`endif
                w_next_overflow = (r_count == w_term);
                w_reload        = (r_count == w_term);
                w_next_count    = (r_count == w_term) ? '0 : r_count + 1'b1;
            end
        end
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_period       <= '0;
            r_compare      <= '0;
            r_load_pending <= 1'b1;
        end else begin
            r_count        <= w_next_count;
            r_overflow     <= w_next_overflow;
            r_load_pending <= 1'b0;
            if (w_reload) begin
                r_period  <= i_period_value;
                r_compare <= i_compare_values;
            end
        end
    end
`ifdef SHADOW_COUNTER_UPDOWN_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_dir       <= UP;
            r_mode      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_dir       <= w_next_dir;
            r_underflow <= w_next_underflow;
            if (w_reload)
                r_mode <= i_updown_mode;
        end
    end
    assign o_counter_underflow = r_underflow;
`else
    assign o_counter_underflow = 1'b0;
`endif
    for (genvar c = 0; c < CHANNELS; c++) begin : g_cmp
        assign o_compare_out[c] = r_count < r_compare[c*BIT_WIDTH +: BIT_WIDTH];
    end
    assign o_counter_value    = r_count;
    assign o_counter_overflow = r_overflow;
endmodule

// File: tb/tb_shadow_compare_counter.sv
// tb_shadow_compare_counter: directed and random checks of shadow_compare_counter against a phase-based model.
module tb_shadow_compare_counter;
    localparam int BW = 8;
    localparam int CH = 3;
    localparam int W  = BW + 2 + CH;
`ifdef SHADOW_COUNTER_UPDOWN_EN
    localparam bit UD = 1'b1;
`else
    localparam bit UD = 1'b0;
`endif
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic [BW-1:0]   per = '0;
    logic [CH*BW-1:0] cmps = '0;
    logic            mode = 1'b0;
    logic [BW-1:0]   cnt;
    logic            ovf;
    logic            unf;
    logic [CH-1:0]   cout;
    int checks = 0;
    int passed = 0;
    // Model: position m_p along the sawtooth or triangle of the current shadow period
    int m_per, m_mode, m_p, m_pending, m_fresh, m_ovf, m_unf;
    int m_cmp[CH];

    shadow_compare_counter #(.BIT_WIDTH(BW), .CHANNELS(CH)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_enable(en),
        .i_period_value(per),
        .i_compare_values(cmps),
`ifdef SHADOW_COUNTER_UPDOWN_EN
        .i_updown_mode(mode),
`endif
        .o_counter_value(cnt),
        .o_counter_overflow(ovf),
        .o_counter_underflow(unf),
        .o_compare_out(cout)
    );

    always #5 clk = ~clk;

    function automatic int mterm();
        return (m_per + (1 << BW) - 1) % (1 << BW);
    endfunction

    function automatic logic [W-1:0] expv();
        int t = mterm();
        int v;
        logic [CH-1:0] c;
        v = (m_mode != 0 && t != 0 && m_p > t) ? 2 * t - m_p : m_p;
        for (int i = 0; i < CH; i++) c[i] = v < m_cmp[i];
        return {v[BW-1:0], m_ovf[0], m_unf[0], c};
    endfunction

    function automatic logic [W-1:0] obs();
        return {cnt, ovf, unf, cout};
    endfunction

    task automatic model_reset();
        m_per = 0; m_mode = 0; m_p = 0; m_pending = 1; m_fresh = 1; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < CH; i++) m_cmp[i] = 0;
    endtask

    task automatic model_load();
        m_per = int'(per);
        m_mode = UD ? int'(mode) : 0;
        for (int i = 0; i < CH; i++) m_cmp[i] = int'(cmps[i*BW +: BW]);
    endtask

    task automatic model_step();
        int t, np;
        m_ovf = 0; m_unf = 0;
        if (m_pending != 0) begin
            model_load();
            m_pending = 0; m_fresh = 1;
        end else if (en) begin
            t = mterm();
            if (m_mode == 0 || t == 0) begin
                np = (m_p + 1) % (t + 1);
                if (np == 0) begin
                    m_ovf = 1; model_load(); m_fresh = 1;
                end
                m_p = np;
            end else if (m_p == 0 && m_fresh == 0) begin
                m_unf = 1; model_load();
                m_p = (mterm() == 0) ? 0 : 1;
            end else begin
                np = (m_p + 1) % (2 * t);
                m_ovf = (np == (t + 1) % (2 * t)) ? 1 : 0;
                m_p = np; m_fresh = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs() !== '0) $display("FAIL reset_async got %h want %h", obs(), {W{1'b0}});
        else passed++;
        cycle();
        checks++;
        if (obs() !== '0) $display("FAIL reset_held got %h want %h", obs(), {W{1'b0}});
        else passed++;
    endtask

    task automatic test_up_basic();
        int ev[11] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        int eo[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [BW:0] want;
        per = 8'd5; cmps = {8'd12, 8'd0, 8'd3}; en = 1'b1; rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            cycle();
            want = {ev[i][BW-1:0], eo[i][0]};
            checks++;
            if ({cnt, ovf} !== want) $display("FAIL up_basic step %0d got %h want %h", i, {cnt, ovf}, want);
            else passed++;
            checks++;
            if (obs() !== expv()) $display("FAIL up_basic_model step %0d got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_period_change();
        int ev[10] = '{2, 3, 4, 0, 1, 2, 0, 1, 2, 0};
        logic [BW-1:0] want;
        cycle();
        checks++;
        if (cnt !== 8'd1) $display("FAIL period_change_start got %0d want 1", cnt);
        else passed++;
        per = 8'd3;
        for (int i = 0; i < 10; i++) begin
            cycle();
            want = ev[i][BW-1:0];
            checks++;
            if (cnt !== want || ovf !== (want == 0)) $display("FAIL period_change step %0d got %0d/%b want %0d/%b", i, cnt, ovf, want, want == 0);
            else passed++;
        end
    endtask

    task automatic test_compare();
        per = 8'd10; cmps = {8'd12, 8'd0, 8'd3};
        for (int i = 0; i < 25; i++) begin
            cycle();
            checks++;
            if (obs() !== expv()) $display("FAIL compare step %0d got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_period_edges();
        per = 8'd0;
        for (int i = 0; i < 530; i++) begin
            cycle();
            checks++;
            if (obs() !== expv()) $display("FAIL period0 step %0d got %h want %h", i, obs(), expv());
            else passed++;
        end
        per = 8'd1;
        for (int i = 0; i < 270; i++) begin
            cycle();
            checks++;
            if (obs() !== expv()) $display("FAIL period1 step %0d got %h want %h", i, obs(), expv());
            else passed++;
        end
        checks++;
        if ({cnt, ovf} !== {8'd0, 1'b1}) $display("FAIL period1_hold got %0d/%b want 0/1", cnt, ovf);
        else passed++;
    endtask

    task automatic test_enable_hold();
        bit hit = 0;
        per = 8'd8;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            checks++;
            if (obs() !== expv()) $display("FAIL hold_run step %0d got %h want %h", i, obs(), expv());
            else passed++;
            hit = (cnt == 8'd7);
        end
        checks++;
        if (!hit) $display("FAIL hold_reach got %0d want 7", cnt);
        else passed++;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if ({cnt, ovf, unf} !== {8'd7, 2'b00}) $display("FAIL hold step %0d got %0d/%b/%b want 7/0/0", i, cnt, ovf, unf);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs() !== '0) $display("FAIL async_reset got %h want %h", obs(), {W{1'b0}});
        else passed++;
        cycle();
        cycle();
        rst = 1'b0; en = 1'b1; per = 8'd8;
        cycle();
        checks++;
        if ({cnt, ovf} !== {8'd0, 1'b0}) $display("FAIL release_load got %0d/%b want 0/0", cnt, ovf);
        else passed++;
        cycle();
        checks++;
        if ({cnt, ovf} !== {8'd1, 1'b0}) $display("FAIL release_count got %0d/%b want 1/0", cnt, ovf);
        else passed++;
    endtask

`ifdef SHADOW_COUNTER_UPDOWN_EN
    task automatic test_updown();
        int ev[13] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1};
        int eo[13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        int eu[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        int mv[13] = '{2, 3, 2, 1, 0, 1, 2, 3, 0, 1, 2, 3, 0};
        int mo[13] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        int mu[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        logic [BW+1:0] want;
        rst = 1'b1; model_reset();
        cycle();
        rst = 1'b0; per = 8'd4; mode = 1'b1; en = 1'b1;
        cycle();
        checks++;
        if ({cnt, ovf, unf} !== '0) $display("FAIL updown_load got %0d/%b/%b want 0/0/0", cnt, ovf, unf);
        else passed++;
        for (int i = 0; i < 13; i++) begin
            cycle();
            want = {ev[i][BW-1:0], eo[i][0], eu[i][0]};
            checks++;
            if ({cnt, ovf, unf} !== want) $display("FAIL updown step %0d got %h want %h", i, {cnt, ovf, unf}, want);
            else passed++;
        end
        mode = 1'b0;
        for (int i = 0; i < 13; i++) begin
            cycle();
            want = {mv[i][BW-1:0], mo[i][0], mu[i][0]};
            checks++;
            if ({cnt, ovf, unf} !== want) $display("FAIL mode_change step %0d got %h want %h", i, {cnt, ovf, unf}, want);
            else passed++;
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                per = ($urandom_range(0, 40) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
                mode = 1'($urandom_range(0, 1));
                for (int c = 0; c < CH; c++) cmps[c*BW +: BW] = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1; model_reset();
                cycle();
                rst = 1'b0;
            end
            cycle();
            checks++;
            if (obs() !== expv()) $display("FAIL random step %0d got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up_basic();
        test_period_change();
        test_compare();
        test_period_edges();
        test_enable_hold();
        test_async_reset();
`ifdef SHADOW_COUNTER_UPDOWN_EN
        test_updown();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/shadow_compare_counter.md
# shadow_compare_counter

Multi-channel timer counter with shadowed period, compare and mode registers. All of them are reloaded only at the period boundary and after reset, so software can write new values at any time without glitching the running period. It produces a wrap/top pulse, a bottom pulse and one compare (PWM-style) output per channel. It is the timebase for PWM generators and periodic event scheduling in the logic block library.

## Interface
- bit_width, 32, width of counter, period and each compare value
- channels, 4, number of compare channels (>= 1)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  count enable; 0 holds the counter
- period_value  in  bit_width  requested period; 0 means 2^bit_width
- compare_values  in  channels*bit_width  channel i at bits [i*bit_width +: bit_width]
- updown_mode  in  1  0 = up (sawtooth), 1 = up-down (triangle); present only with the macro
- counter_value  out  bit_width  current count
- counter_overflow  out  1  one-cycle pulse at wrap (up) or at top turn (up-down)
- counter_underflow  out  1  one-cycle pulse at bottom turn (up-down only)
- compare_out  out  channels  per-channel compare result

## Operation
- Shadow registers: shadow_period, shadow_compare[channels], shadow_mode.
- Terminal value T = shadow_period - 1, modulo 2^bit_width. Period 0 therefore gives T = all ones.
- load_pending flag:
  - Set by reset.
  - The first clock edge with reset low loads all shadows from the inputs and clears the flag.
  - The counter does not advance on that edge, regardless of enable.
- Up mode (shadow_mode = 0), when enable = 1:
  - If counter_value == T: counter_value <= 0, counter_overflow <= 1, shadows reload.
  - Otherwise counter_value <= counter_value + 1.
- Up-down mode (shadow_mode = 1) uses a direction state, UP or DOWN; reset state is UP.
  - UP, counter_value == T: counter_value <= T-1, state DOWN, counter_overflow <= 1.
  - UP, otherwise: counter_value <= counter_value + 1.
  - DOWN, counter_value == 0: counter_value <= 1, state UP, counter_underflow <= 1, shadows reload.
  - DOWN, otherwise: counter_value <= counter_value - 1.
  - Full cycle is 2*(T) clocks.
- Degenerate period: whenever the effective T is 0 (shadow_period == 1, or being loaded as 1), behave as up mode with T = 0.
  - counter_value stays 0.
  - counter_overflow is 1 every enabled cycle.
  - Shadows reload every enabled cycle.
  - State forced to UP.
- On a reload edge, the next counter value and direction are computed from the newly loaded period and mode.
- compare_out[i] = (counter_value < shadow_compare[i]), combinational from registers.
  - Compare 0: always low.
  - Compare > T: always high.
- enable = 0:
  - counter_value and state hold.
  - Both pulse outputs are 0.
  - No reload, except the load_pending reload.
- Pulses are registered and deasserted on the following enabled or disabled edge.

## Timing
- Reset values: counter_value 0, counter_overflow 0, counter_underflow 0, all shadows 0, compare_out all 0, state UP, load_pending 1.
- Reset asserted mid-operation takes effect immediately, with no clock edge required.
- Pulse outputs become visible in the same cycle as the counter value produced by the wrap or turn edge:
  - Up mode: with counter_value 0.
  - Up-down mode: counter_overflow with T-1, counter_underflow with 1.
- Input changes become effective one clock after the next reload edge; they have no effect before that.
- compare_out has zero latency relative to counter_value.

## Configuration
- SHADOW_COUNTER_UPDOWN_EN defined:
  - updown_mode port exists.
  - Up-down logic and direction state are built.
- Not defined:
  - updown_mode port is absent.
  - shadow_mode is constant 0.
  - counter_underflow is tied to 0.
  - Up mode only.

## Test plan
- bit_width 8, period 5, enable 1 after reset release: one load edge holding 0, then 0,1,2,3,4,0,1…; counter_overflow high in each cycle where counter_value returns to 0, every 5 clocks.
- Period changed 5→3 while counter_value = 1: sequence continues 2,3,4,0 using period 5, then 1,2,0,1,2,0.
- channels 3, period 10, compares 3/0/12: compare_out[0] high for counts 0-2 only, [1] never high, [2] always high.
- bit_width 4, period 0: counts 0..15 and wraps; overflow every 16 clocks. Period 1: counter holds 0 and overflow is high every cycle.
- Up-down, period 4 (T = 3): 0,1,2,3,2,1,0,1,…; overflow coincides with the 2 following 3; underflow coincides with the 1 following 0; 6-clock cycle. Mode change to up takes effect only at the next bottom reload.
- Reset asserted at counter 7 with the clock stopped: all outputs 0 immediately. Enable low for 4 clocks holds the count with no pulses. Reset released: first edge loads, second edge counts.
